// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the TPU job sequencer and the bus slave's control decode.
package tpu_seq_pkg;

   localparam int DEF_ADDR_WIDTH     = 8;
   localparam int DEF_TILE_CNT_WIDTH = 4;
   localparam int DEF_TILE_STRIDE    = 16;
   localparam int DEF_RESET_CYCLES   = 2;
   localparam int DEF_TIMEOUT        = 1024;

   // Control opcodes written by the host through the bus slave.
   localparam logic [3:0] OP_RESET      = 4'b1111;
   localparam logic [3:0] OP_FILL_FIFO  = 4'b0001;
   localparam logic [3:0] OP_DRAIN_FIFO = 4'b0010;
   localparam logic [3:0] OP_MULTIPLY   = 4'b0011;

   typedef enum logic [7:0] {
      S_IDLE  = 8'b0000_0001,
      S_RST   = 8'b0000_0010,
      S_FILL  = 8'b0000_0100,
      S_DRAIN = 8'b0000_1000,
      S_MULT  = 8'b0001_0000,
      S_NEXT  = 8'b0010_0000,
      S_ABORT = 8'b0100_0000,
      S_DONE  = 8'b1000_0000
   } seq_state_t;

endpackage

// File: rtl/tpu_seq_wait_timer.sv
// Clear/enable up-counter shared by the sequencer's wait states and its reset dwell.
module tpu_seq_wait_timer #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = $clog2(TIMEOUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   // Holds at TIMEOUT-1 so a stalled wait cannot wrap back to zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count   = count_q;
   assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/tpu_job_sequencer.sv
// Runs a multi-tile matrix job on the TPU core: per tile reset, fill, drain, multiply,
// waiting on the core's done flags, with timeout and abort handling.
module tpu_job_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH,
   parameter int TILE_STRIDE    = DEF_TILE_STRIDE,
   parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [ADDR_WIDTH-1:0]     job_weight_base,
   input  logic [ADDR_WIDTH-1:0]     job_input_base,
   input  logic [ADDR_WIDTH-1:0]     job_output_base,
   input  logic [TILE_CNT_WIDTH-1:0] job_tiles,
   input  logic                      abort,
   output logic                      tpu_reset,
   output logic                      tpu_fill_fifo,
   output logic                      tpu_drain_fifo,
   output logic                      tpu_multiply,
   output logic [ADDR_WIDTH-1:0]     tpu_weight_base,
   output logic [ADDR_WIDTH-1:0]     tpu_input_base,
   output logic [ADDR_WIDTH-1:0]     tpu_output_base,
   input  logic                      tpu_mem_to_fifo_done,
   input  logic                      tpu_fifo_to_arr_done,
   input  logic                      tpu_output_done,
   output logic                      busy,
   output logic                      job_done,
   output logic                      job_error,
   output logic [TILE_CNT_WIDTH-1:0] tile_idx
);

   localparam int CNT_W = $clog2(TIMEOUT);

   seq_state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0]     wbase_q, ibase_q, obase_q;
   logic [ADDR_WIDTH-1:0]     wout_q, iout_q, oout_q;
   logic [TILE_CNT_WIDTH-1:0] tiles_q, tile_idx_q, next_idx;
   logic [ADDR_WIDTH-1:0]     tile_off;
   logic                      err_q;
   logic [CNT_W-1:0]          tmr_count;
   logic                      tmr_expired, tmr_first;

   assign tile_off  = ADDR_WIDTH'(tile_idx_q) * ADDR_WIDTH'(TILE_STRIDE);
   assign next_idx  = tile_idx_q + TILE_CNT_WIDTH'(1);
   assign tmr_first = (tmr_count == '0);

   tpu_seq_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_d != state_q),
      .enable  (state_q != S_IDLE),
      .count   (tmr_count),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wbase_q    <= '0;
         ibase_q    <= '0;
         obase_q    <= '0;
         tiles_q    <= '0;
         tile_idx_q <= '0;
         err_q      <= 1'b0;
         wout_q     <= '0;
         iout_q     <= '0;
         oout_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && job_valid) begin
            wbase_q    <= job_weight_base;
            ibase_q    <= job_input_base;
            obase_q    <= job_output_base;
            tiles_q    <= job_tiles;
            tile_idx_q <= '0;
            err_q      <= (job_tiles == '0);
         end
         if (state_q == S_NEXT) tile_idx_q <= next_idx;
         if (state_d == S_ABORT) err_q <= 1'b1;
         // Bases are loaded on state entry so they are stable for the whole strobe.
         if (state_d == S_FILL && state_q != S_FILL) wout_q <= wbase_q + tile_off;
         if (state_d == S_MULT && state_q != S_MULT) begin
            iout_q <= ibase_q + tile_off;
            oout_q <= obase_q + tile_off;
         end
      end
   end

   // Done flags are ignored in the first cycle of a wait state; abort outranks them.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (job_valid) state_d = (job_tiles == '0) ? S_DONE : S_RST;
         S_RST: begin
            if (abort) state_d = S_ABORT;
            else if (tmr_count == CNT_W'(RESET_CYCLES - 1)) state_d = S_FILL;
         end
         S_FILL: begin
            if (abort) state_d = S_ABORT;
            else if (!tmr_first && tpu_mem_to_fifo_done) state_d = S_DRAIN;
            else if (tmr_expired) state_d = S_ABORT;
         end
         S_DRAIN: begin
            if (abort) state_d = S_ABORT;
            else if (!tmr_first && tpu_fifo_to_arr_done) state_d = S_MULT;
            else if (tmr_expired) state_d = S_ABORT;
         end
         S_MULT: begin
            if (abort) state_d = S_ABORT;
            else if (!tmr_first && tpu_output_done) state_d = S_NEXT;
            else if (tmr_expired) state_d = S_ABORT;
         end
         S_NEXT: begin
            if (abort) state_d = S_ABORT;
            else state_d = (next_idx == tiles_q) ? S_DONE : S_RST;
         end
         S_ABORT: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // job_valid/job_ready: a descriptor transfers on a clock edge where both are high;
   // job_ready is high exactly while IDLE, and the source holds fields stable while valid.
   assign job_ready       = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign job_done        = (state_q == S_DONE);
   assign job_error       = (state_q == S_DONE) && err_q;
   assign tile_idx        = tile_idx_q;
   assign tpu_reset       = (state_q == S_RST) || (state_q == S_ABORT);
   assign tpu_fill_fifo   = (state_q == S_FILL);
   assign tpu_drain_fifo  = (state_q == S_DRAIN);
   assign tpu_multiply    = (state_q == S_MULT);
   assign tpu_weight_base = wout_q;
   assign tpu_input_base  = iout_q;
   assign tpu_output_base = oout_q;

endmodule
